switch_debouncer: RTL and testbench

- Conditions raw board slide switches and push keys before they reach the up/down LED counter and its clock-rate selector.
- Each channel is synchronised into clk, then debounced with a stable-time counter.
- Outputs are clean levels plus one-cycle rise/fall pulses.
- Sits directly upstream of the counter: the counter's sw1..sw4 and reset-key inputs take db_out instead of raw pins.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_channel.sv | 53 +++++
 rtl/switch_debouncer.sv | 44 ++++
 tb/tb_switch_debouncer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants for the switch/key debouncer: board clock, debounce window
// and the channel map used by the up/down LED counter.
package debounce_pkg;

  localparam int CLK_HZ                = 50_000_000;
  localparam int DEBOUNCE_MS           = 10;
  localparam int DEFAULT_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  localparam int SW1_IDX    = 0;
  localparam int SW2_IDX    = 1;
  localparam int SW3_IDX    = 2;
  localparam int SW4_IDX    = 3;
  localparam int RSTKEY_IDX = 4;

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: two-flop synchroniser, stable-time counter and
// registered rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic INIT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic db_out,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int             CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // High in the cycle whose edge commits a new level; the top registers it
  // into any_change alongside the pulses.
  assign accept = (s2 != db_out) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= INIT;
      s2     <= INIT;
      db_out <= INIT;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= raw_in;
      s2   <= s1;
      rise <= accept & s2;
      fall <= accept & ~s2;
      if (s2 == db_out) begin
        cnt <= '0;
      end else if (accept) begin
        db_out <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the board slide switches and reset key feeding the LED counter;
// one independent channel per bit plus a combined change flag.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int               WIDTH         = 5,
  parameter int               STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic [WIDTH-1:0] INIT          = WIDTH'(5'b10000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .INIT          (INIT[i])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw_in (raw_in[i]),
      .db_out (db_out[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .accept (accept[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |accept;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed and randomized bench for switch_debouncer against a sliding-window
// reference model (STABLE_CYCLES=4, WIDTH=5, INIT=5'b10000).
module tb_switch_debouncer;

  localparam int         W    = 5;
  localparam int         S    = 4;
  localparam logic [W-1:0] INIT = 5'b10000;

  logic         clk;
  logic         rst;
  logic [W-1:0] raw_in;
  logic [W-1:0] db_out;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         any_change;

  int vectors;
  int miscompares;

  switch_debouncer #(
    .WIDTH         (W),
    .STABLE_CYCLES (S),
    .INIT          (INIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .db_out     (db_out),
    .rise       (rise),
    .fall       (fall),
    .any_change (any_change)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: s2 is raw delayed two edges; a bit is accepted when the
  // last S sampled s2 values all differ from the current debounced level
  logic [W-1:0] pipe_q[$];
  logic [W-1:0] hist_q[$];
  logic [W-1:0] m_db;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic         m_any;

  task automatic model_reset();
    pipe_q = {INIT, INIT};
    hist_q.delete();
    m_db   = INIT;
    m_rise = '0;
    m_fall = '0;
    m_any  = 1'b0;
  endtask

  task automatic model_edge(input logic [W-1:0] raw);
    logic [W-1:0] smp;
    logic         all_diff;
    smp = pipe_q.pop_front();
    pipe_q.push_back(raw);
    hist_q.push_back(smp);
    if (hist_q.size() > S) void'(hist_q.pop_front());
    m_rise = '0;
    m_fall = '0;
    if (hist_q.size() == S) begin
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < S; j++)
          if (hist_q[j][i] == m_db[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_rise[i] = ~m_db[i];
          m_fall[i] = m_db[i];
        end
      end
    end
    m_db  = m_db ^ (m_rise | m_fall);
    m_any = |(m_rise | m_fall);
  endtask

  // scoreboard helpers
  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_vec({tag, "_db"}, db_out, INIT);
    check_vec({tag, "_rise"}, rise, '0);
    check_vec({tag, "_fall"}, fall, '0);
    check_vec({tag, "_any"}, {4'b0, any_change}, '0);
  endtask

  // driver: enters and leaves at a falling edge
  task automatic step(input logic [W-1:0] v);
    raw_in = v;
    @(posedge clk);
    #1;
    model_edge(v);
    check_vec("db_out", db_out, m_db);
    check_vec("rise", rise, m_rise);
    check_vec("fall", fall, m_fall);
    check_vec("any_change", {4'b0, any_change}, {4'b0, m_any});
    @(negedge clk);
  endtask

  // asynchronous reset asserted mid-cycle, held over one edge, released at negedge
  task automatic do_reset(input logic [W-1:0] v);
    #2;
    rst    = 1'b0;
    raw_in = v;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [W-1:0] v;
  int           first;
  int           nr;
  int           na;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    raw_in      = INIT;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("power_on");
    @(negedge clk);
    rst = 1'b1;

    // clean press on bit 0
    v = INIT;
    repeat (3) step(v);
    v[0] = 1'b1;
    first = -1; nr = 0;
    for (int k = 0; k < 8; k++) begin
      step(v);
      if (rise[0]) begin nr++; if (first < 0) first = k; end
    end
    check_int("press_edge", first, 5);
    check_int("press_pulses", nr, 1);

    // glitch on bit 1: three cycles high is one short of acceptance
    nr = 0;
    v[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin step(v); nr += int'(rise[1] | fall[1]); end
    v[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin step(v); nr += int'(rise[1] | fall[1]); end
    check_int("glitch_pulses", nr, 0);
    check_int("glitch_db", int'(db_out[1]), 0);

    // bounce on bit 2: 1,0,1,0 then final 1 held
    nr = 0; first = -1;
    for (int k = 0; k < 4; k++) begin
      v[2] = (k % 2 == 0);
      step(v);
      nr += int'(rise[2]);
    end
    v[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(v);
      if (rise[2]) begin nr++; if (first < 0) first = k; end
    end
    check_int("bounce_edge", first, 5);
    check_int("bounce_pulses", nr, 1);

    // simultaneous key release (bit 4) and switch on (bit 3)
    v[4] = 1'b0; v[3] = 1'b1;
    first = -1; na = 0;
    for (int k = 0; k < 8; k++) begin
      step(v);
      na += int'(any_change);
      if (rise[3] && fall[4] && any_change && first < 0) first = k;
    end
    check_int("multi_edge", first, 5);
    check_int("multi_any_pulses", na, 1);
    check_vec("multi_db", db_out, 5'b01101);

    // async reset while outputs are away from INIT
    do_reset(v);
    v = INIT;
    repeat (3) step(v);

    // reset mid-count, then full debounce after release
    v[0] = 1'b1;
    nr = 0;
    for (int k = 0; k < 2; k++) begin step(v); nr += int'(|rise | |fall); end
    do_reset(v);
    first = -1;
    for (int k = 0; k < 9; k++) begin
      step(v);
      if (rise[0]) begin nr++; if (first < 0) first = k; end
    end
    check_int("post_reset_edge", first, 5);
    check_int("post_reset_pulses", nr, 1);

    // randomized: sparse per-bit toggles so some levels survive the window
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 5) == 0) v[i] = ~v[i];
      step(v);
      if ($urandom_range(0, 199) == 0) do_reset(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
